// File: rtl/ps2_event_queue_if.sv
// Keyboard event queue bus: scan-byte input side, CPU read side and status.
// master = byte source / CPU side, slave = the event queue itself.
interface ps2_event_queue_if #(
    parameter int AW = 4
);
    logic          scan_valid;
    logic [7:0]    scan_byte;
    logic [7:0]    scan_ascii;
    logic          ren;
    logic          ovf_clr;
    logic [15:0]   data;
    logic          ready;
    logic [AW:0]   count;
    logic          overflow;
    logic [2:0]    mods;

    modport master (
        output scan_valid, scan_byte, scan_ascii, ren, ovf_clr,
        input  data, ready, count, overflow, mods
    );

    modport slave (
        input  scan_valid, scan_byte, scan_ascii, ren, ovf_clr,
        output data, ready, count, overflow, mods
    );
endinterface

// File: rtl/ps2_event_queue.sv
// PS/2 keyboard event queue: E0/F0 prefix sequencing, live modifier tracking
// and a FIFO of packed 16-bit key events popped by CPU reads.
// Optional build macro: PS2Q_DROP_BREAK_EN (break events update mods only).
module ps2_event_queue #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic            clk,
    input  logic            rst,
    ps2_event_queue_if.slave bus
);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q;
    logic [2:0]      mods_q, mods_d;       // {alt, ctrl, shift}
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;

    logic            emit, ev_brk, ev_ext, is_ctl, raw, push;
    logic [15:0]     ev_word;
    logic            full, pop, do_push, drop;

    // Prefix decode, modifier update and event packing for the current byte
    always_comb begin
        emit    = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        state_d = state_q;
        is_ctl  = bus.scan_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        if (bus.scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.scan_byte == 8'hE0)      state_d = S_EXT;
                    else if (bus.scan_byte == 8'hF0) state_d = S_BRK;
                    else if (!is_ctl)                emit    = 1'b1;
                end
                S_EXT: begin
                    if (bus.scan_byte == 8'hF0)      state_d = S_EXT_BRK;
                    else if (bus.scan_byte != 8'hE0) begin
                        emit = 1'b1; ev_ext = 1'b1; state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (bus.scan_byte == 8'hE0)      state_d = S_EXT_BRK;
                    else if (bus.scan_byte != 8'hF0) begin
                        emit = 1'b1; ev_brk = 1'b1; state_d = S_IDLE;
                    end
                end
                default: begin
                    if (bus.scan_byte != 8'hE0 && bus.scan_byte != 8'hF0) begin
                        emit = 1'b1; ev_brk = 1'b1; ev_ext = 1'b1; state_d = S_IDLE;
                    end
                end
            endcase
        end

        // Left/right shift share one bit; any shift break clears it
        mods_d = mods_q;
        if (emit) begin
            if ((bus.scan_byte == 8'h12 || bus.scan_byte == 8'h59) && !ev_ext)
                mods_d[0] = !ev_brk;
            if (bus.scan_byte == 8'h14) mods_d[1] = !ev_brk;
            if (bus.scan_byte == 8'h11) mods_d[2] = !ev_brk;
        end

        // Event carries the post-update modifier state
        raw     = (bus.scan_ascii == 8'h00);
        ev_word = {ev_brk, ev_ext, mods_d[0], mods_d[1], mods_d[2], raw, 2'b00,
                   raw ? bus.scan_byte : bus.scan_ascii};
    end

`ifdef PS2Q_DROP_BREAK_EN
    assign push = emit && !ev_brk;
`else
    assign push = emit;
`endif

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = bus.ren && (count_q != '0);
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // Prefix FSM with stall timeout; modifiers registered alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            mods_q  <= '0;
        end else begin
            mods_q <= mods_d;
            if (bus.scan_valid) begin
                state_q <= state_d;
                tmo_q   <= '0;
            end else if (state_q != S_IDLE) begin
                if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_q <= S_IDLE;
                    tmo_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    // Event storage; contents behind the pointers need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= ev_word;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= (ovf_q && !bus.ovf_clr) || drop;
        end
    end

    assign bus.data     = (count_q != '0) ? mem_q[rptr_q] : 16'h0000;
    assign bus.ready    = (count_q != '0);
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.mods     = mods_q;
endmodule

// File: tb/tb_ps2_event_queue.sv
// Self-checking bench for ps2_event_queue: directed plan steps followed by
// randomized traffic, all compared against a queue-based keyboard model.
module tb_ps2_event_queue;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_event_queue_if #(.AW(AW)) bus ();

    ps2_event_queue #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    logic [15:0] mq [$];
    bit          m_pend, m_ext, m_brk, m_ovf;
    bit          m_shift, m_ctrl, m_alt;
    int          m_gap;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        logic [15:0] hd;
        hd = (mq.size() > 0) ? mq[0] : 16'h0000;
        chk({tag, ".data"},  32'(bus.data), 32'(hd));
        chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        chk({tag, ".ready"}, 32'(bus.ready), 32'(mq.size() > 0));
        chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".mods"},  32'(bus.mods), 32'({m_alt, m_ctrl, m_shift}));
    endtask

    task automatic model_clear();
        mq.delete();
        m_pend = 0; m_ext = 0; m_brk = 0; m_ovf = 0;
        m_shift = 0; m_ctrl = 0; m_alt = 0; m_gap = 0;
    endtask

    // A completed key: update modifiers, build the event word
    task automatic model_key(input logic [7:0] b, input logic [7:0] a, input bit brk,
                             input bit ext, output bit have, output logic [15:0] ev);
        bit raw;
        if ((b == 8'h12 || b == 8'h59) && !ext) m_shift = !brk;
        if (b == 8'h14) m_ctrl = !brk;
        if (b == 8'h11) m_alt  = !brk;
        raw = (a == 8'h00);
        ev  = 16'(brk) * 16'h8000 + 16'(ext) * 16'h4000 + 16'(m_shift) * 16'h2000
            + 16'(m_ctrl) * 16'h1000 + 16'(m_alt) * 16'h0800 + 16'(raw) * 16'h0400
            + (raw ? 16'(b) : 16'(a));
`ifdef PS2Q_DROP_BREAK_EN
        have = !brk;
`else
        have = 1'b1;
`endif
    endtask

    task automatic model_byte(input logic [7:0] b, input logic [7:0] a,
                              output bit have, output logic [15:0] ev);
        have = 0; ev = 16'h0;
        m_gap = 0;
        if (b == 8'hE0)      begin m_pend = 1; m_ext = 1; end
        else if (b == 8'hF0) begin m_pend = 1; m_brk = 1; end
        else if (!m_pend && (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                             b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
        end else begin
            model_key(b, a, m_brk, m_ext, have, ev);
            m_pend = 0; m_ext = 0; m_brk = 0;
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare
    task automatic step(input bit v, input logic [7:0] b, input logic [7:0] a,
                        input bit rd, input bit clr);
        bit have, full, popped;
        logic [15:0] ev;
        bus.scan_valid = v; bus.scan_byte = b; bus.scan_ascii = a;
        bus.ren = rd; bus.ovf_clr = clr;
        @(posedge clk); #1;
        bus.scan_valid = 0; bus.ren = 0; bus.ovf_clr = 0;
        have = 0; ev = 16'h0;
        if (v) model_byte(b, a, have, ev);
        else begin
            m_gap++;
            if (m_pend && m_gap == TIMEOUT) begin m_pend = 0; m_ext = 0; m_brk = 0; end
        end
        full   = (mq.size() == DEPTH);
        popped = rd && (mq.size() > 0);
        if (popped) void'(mq.pop_front());
        if (have) begin
            if (!full || popped) mq.push_back(ev);
            else m_ovf = 1;
        end
        if (have && full && !popped) m_ovf = 1;
        else if (clr) m_ovf = 0;
        chk_all("step");
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_clear();
        chk_all("reset");
    endtask

    task automatic drain();
        repeat (DEPTH + 1) step(0, 8'h00, 8'h00, 1, 0);
    endtask

    task automatic key(input logic [7:0] b, input logic [7:0] a);
        step(1, b, a, 0, 0);
    endtask

    initial begin
        logic [7:0] pool [12];
        bus.scan_valid = 0; bus.scan_byte = 0; bus.scan_ascii = 0;
        bus.ren = 0; bus.ovf_clr = 0;
        model_clear();

        // Reset state
        do_reset();
        chk("rst.data",  32'(bus.data), 32'h0);
        chk("rst.ready", 32'(bus.ready), 32'h0);
        chk("rst.count", 32'(bus.count), 32'h0);
        chk("rst.ovf",   32'(bus.overflow), 32'h0);
        chk("rst.mods",  32'(bus.mods), 32'h0);

        // Make / break of a plain key
        key(8'h1C, 8'h61); key(8'hF0, 8'h00); key(8'h1C, 8'h61);
        chk("mk.head", 32'(bus.data), 32'h0061);
`ifdef PS2Q_DROP_BREAK_EN
        chk("mk.count", 32'(bus.count), 32'd1);
`else
        chk("mk.count", 32'(bus.count), 32'd2);
        step(0, 8'h00, 8'h00, 1, 0);
        chk("brk.head", 32'(bus.data), 32'h8061);
`endif
        drain();

        // Shift modifier
        key(8'h12, 8'h00); key(8'h1C, 8'h61);
        chk("sh.head", 32'(bus.data), 32'h2412);
        chk("sh.mods", 32'(bus.mods), 32'h1);
        step(0, 8'h00, 8'h00, 1, 0);
        chk("sh.key", 32'(bus.data), 32'h2061);
        step(0, 8'h00, 8'h00, 1, 0);
        key(8'hF0, 8'h00); key(8'h12, 8'h00);
        chk("shb.mods", 32'(bus.mods), 32'h0);
`ifndef PS2Q_DROP_BREAK_EN
        chk("shb.head", 32'(bus.data), 32'h8412);
`endif
        drain();

        // Extended make and extended break
        key(8'hE0, 8'h00); key(8'h75, 8'h00);
        chk("ext.head", 32'(bus.data), 32'h4475);
        drain();
        key(8'hE0, 8'h00); key(8'hF0, 8'h00); key(8'h75, 8'h00);
`ifndef PS2Q_DROP_BREAK_EN
        chk("extb.head", 32'(bus.data), 32'hC475);
`endif
        drain();

        // Overflow, clear, full pop+push, clear colliding with a new drop
        repeat (DEPTH + 1) key(8'h1C, 8'h61);
        chk("ovf.count", 32'(bus.count), 32'd16);
        chk("ovf.flag",  32'(bus.overflow), 32'h1);
        chk("ovf.head",  32'(bus.data), 32'h0061);
        step(0, 8'h00, 8'h00, 0, 1);
        chk("ovf.clr", 32'(bus.overflow), 32'h0);
        step(1, 8'h1C, 8'h61, 1, 0);
        chk("full.rw", 32'(bus.count), 32'd16);
        step(1, 8'h1C, 8'h61, 0, 1);
        chk("ovf.collide", 32'(bus.overflow), 32'h1);
        step(0, 8'h00, 8'h00, 0, 1);
        drain();

        // Prefix timeout discards E0; within the window it survives
        key(8'hE0, 8'h00);
        repeat (TIMEOUT) step(0, 8'h00, 8'h00, 0, 0);
        key(8'h1C, 8'h61);
        chk("tmo.head", 32'(bus.data), 32'h0061);
        drain();
        key(8'hE0, 8'h00);
        repeat (TIMEOUT / 2) step(0, 8'h00, 8'h00, 0, 0);
        key(8'h75, 8'h00);
        chk("tmo.keep", 32'(bus.data), 32'h4475);
        drain();
        key(8'hAA, 8'h00);
        chk("ctl.drop", 32'(bus.count), 32'd0);

        // Reset mid-prefix, then ren on empty
        key(8'hE0, 8'h00);
        key(8'h1C, 8'h61);
        do_reset();
        key(8'hE0, 8'h00);
        do_reset();
        key(8'h1C, 8'h61);
        chk("rstp.head",  32'(bus.data), 32'h0061);
        chk("rstp.count", 32'(bus.count), 32'd1);
        step(0, 8'h00, 8'h00, 1, 0);
        step(0, 8'h00, 8'h00, 1, 0);
        chk("empty.count", 32'(bus.count), 32'd0);
        chk("empty.data",  32'(bus.data), 32'h0);

        // Randomized traffic against the model
        pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11,
                 8'hAA, 8'h1C, 8'h75, 8'h00, 8'hFA, 8'h33};
        for (int i = 0; i < 600; i++) begin
            logic [7:0] b, a;
            bit v, rd, clr;
            b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            a   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            v   = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 9) < 3);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(v, b, a, rd, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ps2_event_queue.md
# ps2_event_queue

Keyboard event controller between the PS/2 byte receiver and the CPU's memory-mapped keyboard port. Consumes one-cycle-strobed scan bytes (with their table-decoded ASCII), sequences the E0/F0 prefix protocol and tracks live modifier state. Packs each complete key into a 16-bit event and buffers events in a FIFO, so the CPU no longer loses keys between polls. Pops the FIFO head on each CPU read.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AW`, 4: log2(DEPTH).
- `TIMEOUT`, 100000: clk cycles a prefix state may wait for its next byte.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `scan_valid`  in  1  one-cycle strobe; `scan_byte`/`scan_ascii` valid this cycle.
- `scan_byte`  in  8  raw scan byte.
- `scan_ascii`  in  8  unshifted ASCII lookup of `scan_byte`; 0 = no mapping.
- `ren`  in  1  CPU read strobe; pops head when non-empty.
- `ovf_clr`  in  1  clears `overflow`.
- `data`  out  16  head event; 0x0000 when empty.
- `ready`  out  1  FIFO non-empty.
- `count`  out  AW+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: an event was dropped.
- `mods`  out  3  live {alt, ctrl, shift}.

## Operation
- Event word: [15] break, [14] extended, [13] shift, [12] ctrl, [11] alt, [10] raw, [9:8] 0, [7:0] = `scan_ascii` if non-zero (raw=0), else `scan_byte` (raw=1).
- Prefix FSM, advances only on `scan_valid`:
  - IDLE: E0→EXT; F0→BRK; control bytes 00, AA, EE, FA, FE, FF dropped, stay IDLE; else emit (break=0, ext=0).
  - EXT: F0→EXT_BRK; E0 stays EXT; else emit (break=0, ext=1) → IDLE.
  - BRK: F0 stays BRK; E0→EXT_BRK; else emit (break=1, ext=0) → IDLE.
  - EXT_BRK: E0/F0 stay; else emit (break=1, ext=1) → IDLE.
- Modifiers, applied on emit: 12 or 59 (ext=0) → shift; 14 (either ext) → ctrl; 11 (either ext) → alt; set on make, cleared on break. Left/right shift are not distinguished: any break clears shift. The emitted word carries modifier state after the update: a shift make has [13]=1 and a shift break has [13]=0.
- Modifier events are enqueued like any other key.
- Timeout: a counter runs while the FSM is in a non-IDLE state and reloads on each `scan_valid`. When it reaches TIMEOUT-1, the FSM returns to IDLE and the partial prefix is discarded silently.
- FIFO: circular, AW-bit read/write pointers that wrap at DEPTH.
  - Push when not full, or when full with a pop in the same cycle. A full FIFO popped and pushed in one cycle keeps `count` = DEPTH.
  - A push into a full FIFO without a pop drops the new event and sets `overflow`.
  - `ren` while empty is ignored.
  - `ovf_clr` and a new overflow in the same cycle: `overflow` stays set.

## Timing
- Reset values: FSM IDLE, timeout counter 0, pointers 0, `count`=0, `ready`=0, `data`=0, `overflow`=0, `mods`=0.
- `rst` mid-prefix or mid-burst discards all state, including buffered events.
- Latency: `scan_valid` of the final byte sampled at edge N → event in FIFO and `mods` updated after edge N. With the FIFO previously empty, `data`/`ready` are valid in the following cycle.
- Pop: `ren` sampled at edge N → next head on `data` (or 0 if now empty) after edge N. `data` is combinational from the head entry, gated by non-empty.
- Throughput: one byte per cycle accepted; back-to-back `scan_valid` is legal.

## Configuration
- `PS2Q_DROP_BREAK_EN`:
  - Defined: break events still update `mods` but are not enqueued, so the CPU sees make events only.
  - Undefined: all events are enqueued.

## Test plan
- Bytes 1C (ascii 61), F0, 1C → macro undefined: events 0x0061 then 0x8061, `count`=2; with `PS2Q_DROP_BREAK_EN`: only 0x0061.
- Byte 12 (ascii 0) then 1C (ascii 61) → events 0x2412 then 0x2061, `mods`=3'b001. Then F0 12 → event 0x8412, `mods`=0.
- Bytes E0, 75 (ascii 0) → event 0x4475. Then E0, F0, 75 → 0xC475.
- 17 pushes of byte 1C into DEPTH=16 without `ren` → `count`=16, `overflow`=1, head 0x0061. `ovf_clr` → `overflow`=0. `ren` and a push in the same cycle while full → `count` stays 16.
- Byte E0, then no bytes for TIMEOUT cycles, then 1C → event 0x0061 (ext=0). Byte AA in IDLE → nothing enqueued.
- Byte E0, then `rst` asserted, then 1C → event 0x0061, `count`=1. `ren` on empty → `count`=0, `data`=0.
